// File: rtl/bram_arb_pkg.sv
// ---------------------------------------------------------------------------
// bram_arb_pkg
// Shared types and defaults for the BRAM port-B arbiter slice.
//   req_id_e    : requester identity (REQ_COMPUTE = layer compute engine,
//                 REQ_WRITER = result writer)
//   rd_tag_t    : read-response tag {valid, id} carried down the latency pipe
//   *_DEFAULT   : default read latency and port-B geometry
//   makeTag     : builds a tag from a valid bit and requester id
//   tagHits     : true when a tag is valid and belongs to the given requester
// ---------------------------------------------------------------------------
package bram_arb_pkg;

   typedef enum logic {
      REQ_COMPUTE = 1'b0,
      REQ_WRITER  = 1'b1
   } req_id_e;

   // Read latency of port B, counted from the registered enable to valid
   // dout. Legal range is 1..4.
   localparam int BRAM_RD_LAT_DEFAULT = 2;
   localparam int BRAM_ADDR_W_DEFAULT = 10;
   localparam int BRAM_DATA_W_DEFAULT = 32;

   typedef struct packed {
      logic    valid;
      req_id_e id;
   } rd_tag_t;

   function automatic rd_tag_t makeTag(input logic valid, input req_id_e id);
      rd_tag_t t;
      t.valid = valid;
      t.id    = id;
      return t;
   endfunction

   function automatic logic tagHits(input rd_tag_t t, input req_id_e id);
      return t.valid && (t.id == id);
   endfunction

endpackage

// File: rtl/bram_rr_arb2.sv
// ---------------------------------------------------------------------------
// bram_rr_arb2
// Two-input round-robin grant. A lone requester is granted; on a conflict
// the grant goes to the requester that was not granted last. The `last`
// pointer only moves when a grant is actually issued, so idle cycles do not
// disturb fairness.
// Ports:
//   clk_i    in  clock
//   rst_ni   in  asynchronous active-low reset (last -> REQ_WRITER so that
//                REQ_COMPUTE wins the first conflict)
//   valid_i  in  [1:0] request valids, bit N = requester N
//   grant_o  out [1:0] one-hot (or zero) grant, combinational from valid_i
//                and the registered last pointer
// ---------------------------------------------------------------------------
module bram_rr_arb2
   import bram_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] valid_i,
   output logic [1:0] grant_o
);

   req_id_e last_q;
   req_id_e last_d;

   // Grant decision and pointer update. Every grant is an acceptance
   // because the requester's ready is the grant itself.
   always_comb begin
      grant_o = 2'b00;
      last_d  = last_q;
      unique case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = (last_q == REQ_WRITER) ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
      if (grant_o[0]) begin
         last_d = REQ_COMPUTE;
      end else if (grant_o[1]) begin
         last_d = REQ_WRITER;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= REQ_WRITER;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/bram_portb_arbiter.sv
// ---------------------------------------------------------------------------
// bram_portb_arbiter
// Shares BRAM port B between the layer compute engine (requester 0) and the
// result writer (requester 1). One command is accepted per cycle, registered
// onto BRAM_PORTB_*, and every accepted read pushes a tag into an
// RD_LAT+1 deep pipe; the tag leaving the pipe steers BRAM_PORTB_dout back
// to the requester that issued the read.
// Parameters:
//   RD_LAT  BRAM read latency from registered enable to valid dout (1..4)
//   ADDR_W  port-B word-address width
//   DATA_W  port-B data width
// Ports:
//   s_axi_aclk       in   single clock (also the BRAM port-B clock)
//   s_axi_aresetn    in   asynchronous active-low reset
//   reqN_valid       in   requester N command valid (N = 0, 1)
//   reqN_ready       out  command accepted this cycle (combinational)
//   reqN_we          in   1 = write, 0 = read
//   reqN_addr        in   word address
//   reqN_wdata       in   write data
//   reqN_rvalid      out  one-cycle read-data-valid pulse
//   reqN_rdata       out  read data, zero while reqN_rvalid is low
//   BRAM_PORTB_en    out  registered port enable
//   BRAM_PORTB_we    out  registered write enable
//   BRAM_PORTB_addr  out  registered address
//   BRAM_PORTB_din   out  registered write data
//   BRAM_PORTB_dout  in   BRAM read data
// ---------------------------------------------------------------------------
module bram_portb_arbiter
   import bram_arb_pkg::*;
#(
   parameter int RD_LAT = BRAM_RD_LAT_DEFAULT,
   parameter int ADDR_W = BRAM_ADDR_W_DEFAULT,
   parameter int DATA_W = BRAM_DATA_W_DEFAULT
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,

   output logic              BRAM_PORTB_en,
   output logic              BRAM_PORTB_we,
   output logic [ADDR_W-1:0] BRAM_PORTB_addr,
   output logic [DATA_W-1:0] BRAM_PORTB_din,
   input  logic [DATA_W-1:0] BRAM_PORTB_dout
);

   logic [1:0]        grant;

   logic              cmdValid;
   req_id_e           cmdId;
   logic              cmdWe;
   logic [ADDR_W-1:0] cmdAddr;
   logic [DATA_W-1:0] cmdWdata;

   logic              portEn_q,   portEn_d;
   logic              portWe_q,   portWe_d;
   logic [ADDR_W-1:0] portAddr_q, portAddr_d;
   logic [DATA_W-1:0] portDin_q,  portDin_d;

   rd_tag_t           tagPipe_q [RD_LAT+1];
   rd_tag_t           tagPipe_d [RD_LAT+1];
   rd_tag_t           exitTag;

   bram_rr_arb2 u_arb (
      .clk_i   (s_axi_aclk),
      .rst_ni  (s_axi_aresetn),
      .valid_i ({req1_valid, req0_valid}),
      .grant_o (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // Select the accepted requester's command fields.
   always_comb begin
      cmdValid = grant[0] | grant[1];
      cmdId    = grant[1] ? REQ_WRITER : REQ_COMPUTE;
      cmdWe    = grant[1] ? req1_we    : req0_we;
      cmdAddr  = grant[1] ? req1_addr  : req0_addr;
      cmdWdata = grant[1] ? req1_wdata : req0_wdata;
   end

   // Without an acceptance the port goes idle (en/we low) but addr/din keep
   // their last values so the BRAM inputs do not toggle needlessly.
   always_comb begin
      portEn_d   = cmdValid;
      portWe_d   = cmdValid & cmdWe;
      portAddr_d = portAddr_q;
      portDin_d  = portDin_q;
      if (cmdValid) begin
         portAddr_d = cmdAddr;
         portDin_d  = cmdWdata;
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         portEn_q   <= 1'b0;
         portWe_q   <= 1'b0;
         portAddr_q <= '0;
         portDin_q  <= '0;
      end else begin
         portEn_q   <= portEn_d;
         portWe_q   <= portWe_d;
         portAddr_q <= portAddr_d;
         portDin_q  <= portDin_d;
      end
   end

   assign BRAM_PORTB_en   = portEn_q;
   assign BRAM_PORTB_we   = portWe_q;
   assign BRAM_PORTB_addr = portAddr_q;
   assign BRAM_PORTB_din  = portDin_q;

   // Stage 0 is loaded at the accept edge, which puts the tag at stage
   // RD_LAT exactly when the BRAM presents dout for that read: one edge for
   // the command register plus RD_LAT edges inside the BRAM.
   always_comb begin
      tagPipe_d[0] = makeTag(cmdValid & ~cmdWe, cmdId);
      for (int i = 1; i <= RD_LAT; i++) begin
         tagPipe_d[i] = tagPipe_q[i-1];
      end
   end

   // Reset flushes every in-flight tag, so reads caught by a reset never
   // produce a response.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         for (int i = 0; i <= RD_LAT; i++) begin
            tagPipe_q[i] <= makeTag(1'b0, REQ_COMPUTE);
         end
      end else begin
         for (int i = 0; i <= RD_LAT; i++) begin
            tagPipe_q[i] <= tagPipe_d[i];
         end
      end
   end

   assign exitTag = tagPipe_q[RD_LAT];

   // Response demux. Only one tag exits per cycle, so at most one rvalid is
   // high; rdata is forced to zero on the idle side.
   always_comb begin
      req0_rvalid = tagHits(exitTag, REQ_COMPUTE);
      req1_rvalid = tagHits(exitTag, REQ_WRITER);
      req0_rdata  = req0_rvalid ? BRAM_PORTB_dout : '0;
      req1_rdata  = req1_rvalid ? BRAM_PORTB_dout : '0;
   end

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_portb_arbiter
// Drives three arbiter instances (RD_LAT = 1, 2, 4) with identical stimulus,
// each attached to its own write-first BRAM model. A scoreboard memory and a
// list of accepted reads indexed by accept edge give the expected ready,
// port-B command and read response of every instance on every cycle.
// ---------------------------------------------------------------------------
module tb_bram_portb_arbiter;

   localparam int NI        = 3;
   localparam int MAXC      = 40000;
   localparam int RAND_CMDS = 10000;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
   logic [9:0]  a0 = '0, a1 = '0;
   logic [31:0] d0 = '0, d1 = '0;

   logic        rdy0 [NI];
   logic        rdy1 [NI];
   logic        rv0  [NI];
   logic        rv1  [NI];
   logic [31:0] rd0  [NI];
   logic [31:0] rd1  [NI];
   logic        bEn  [NI];
   logic        bWe  [NI];
   logic [9:0]  bAddr[NI];
   logic [31:0] bDin [NI];
   logic [31:0] bDout[NI];

   int testsRun    = 0;
   int testsFailed = 0;
   int edgeCnt     = 0;

   // Model state
   bit          lastM = 1'b1;
   bit          accRd  [MAXC];
   bit          accId  [MAXC];
   logic [31:0] accData[MAXC];
   bit          rstAt  [MAXC];
   logic [31:0] smem   [1024];
   logic        expEn = 1'b0, expWe = 1'b0;
   logic [9:0]  expAddr = '0;
   logic [31:0] expDin  = '0;

   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   initial begin
      #(10 * 45000);
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int latOf(input int g);
      return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : gInst
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      logic [31:0] mem  [1024];
      logic [31:0] pipe [4];

      bram_portb_arbiter #(.RD_LAT(L), .ADDR_W(10), .DATA_W(32)) dut (
         .s_axi_aclk      (clk),
         .s_axi_aresetn   (rst_n),
         .req0_valid      (v0),
         .req0_ready      (rdy0[g]),
         .req0_we         (w0),
         .req0_addr       (a0),
         .req0_wdata      (d0),
         .req0_rvalid     (rv0[g]),
         .req0_rdata      (rd0[g]),
         .req1_valid      (v1),
         .req1_ready      (rdy1[g]),
         .req1_we         (w1),
         .req1_addr       (a1),
         .req1_wdata      (d1),
         .req1_rvalid     (rv1[g]),
         .req1_rdata      (rd1[g]),
         .BRAM_PORTB_en   (bEn[g]),
         .BRAM_PORTB_we   (bWe[g]),
         .BRAM_PORTB_addr (bAddr[g]),
         .BRAM_PORTB_din  (bDin[g]),
         .BRAM_PORTB_dout (bDout[g])
      );

      // Write-first BRAM with L cycles from sampled enable to dout.
      initial begin
         for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
         for (int i = 0; i < 4; i++) pipe[i] = '0;
         forever begin
            @(posedge clk);
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            if (bEn[g]) begin
               if (bWe[g]) begin
                  mem[bAddr[g]] = bDin[g];
                  pipe[0]       = bDin[g];
               end else begin
                  pipe[0] = mem[bAddr[g]];
               end
            end
         end
      end

      assign bDout[g] = pipe[L-1];
   end

   task automatic compareBit(input string name, input int inst, input logic act, input logic exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s inst%0d cycle %0d: got %b, expected %b", name, inst, edgeCnt, act, exp);
      end
   endtask

   task automatic compareWord(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s inst%0d cycle %0d: got %08h, expected %08h", name, inst, edgeCnt, act, exp);
      end
   endtask

   function automatic bit droppedBetween(input int acc, input int now);
      for (int m = acc + 1; m <= now; m++) begin
         if (rstAt[m]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Checks every instance against the model for the current cycle, then
   // advances the model by the acceptance (if any) at the coming edge.
   task automatic checkOutput(output bit g0, output bit g1);
      int          n;
      int          acc;
      bit          e0, e1, ev0, ev1, selId, selWe;
      logic [9:0]  selAddr;
      logic [31:0] selData, ed;
      n  = edgeCnt;
      g0 = 1'b0;
      g1 = 1'b0;
      if (n >= MAXC) begin
         $display("[TB] FAIL cycleBudget: got cycle %0d, expected below %0d", n, MAXC);
         $fatal(1, "[TB] cycle budget exhausted");
      end
      if (!rst_n) begin
         rstAt[n] = 1'b1;
         lastM    = 1'b1;
         expEn    = 1'b0;
         expWe    = 1'b0;
         expAddr  = '0;
         expDin   = '0;
      end
      e0 = rst_n && v0 && (!v1 || lastM);
      e1 = rst_n && v1 && (!v0 || !lastM);
      for (int g = 0; g < NI; g++) begin
         if (rst_n) begin
            compareBit("req0_ready", g, rdy0[g], e0);
            compareBit("req1_ready", g, rdy1[g], e1);
         end
         compareBit("bram_en", g, bEn[g], expEn);
         compareBit("bram_we", g, bWe[g], expWe);
         compareWord("bram_addr", g, 32'(bAddr[g]), 32'(expAddr));
         compareWord("bram_din", g, bDin[g], expDin);
         ev0 = 1'b0;
         ev1 = 1'b0;
         ed  = '0;
         acc = n - 1 - latOf(g);
         if (acc >= 0 && accRd[acc] && !droppedBetween(acc, n)) begin
            if (accId[acc]) ev1 = 1'b1;
            else            ev0 = 1'b1;
            ed = accData[acc];
         end
         compareBit("req0_rvalid", g, rv0[g], ev0);
         compareBit("req1_rvalid", g, rv1[g], ev1);
         if (ev0) compareWord("req0_rdata", g, rd0[g], ed);
         if (ev1) compareWord("req1_rdata", g, rd1[g], ed);
         if (!rst_n) begin
            compareWord("req0_rdata_rst", g, rd0[g], 32'h0);
            compareWord("req1_rdata_rst", g, rd1[g], 32'h0);
         end
      end
      if (e0 || e1) begin
         g0      = e0;
         g1      = e1;
         selId   = e1;
         selWe   = e1 ? w1 : w0;
         selAddr = e1 ? a1 : a0;
         selData = e1 ? d1 : d0;
         expEn   = 1'b1;
         expWe   = selWe;
         expAddr = selAddr;
         expDin  = selData;
         if (selWe) begin
            smem[selAddr] = selData;
         end else begin
            accRd[n]   = 1'b1;
            accId[n]   = selId;
            accData[n] = smem[selAddr];
         end
         lastM = selId;
      end else begin
         expEn = 1'b0;
         expWe = 1'b0;
      end
   endtask

   task automatic applyStimulus(
      input  logic rstn,
      input  logic iv0, input logic iw0, input logic [9:0] ia0, input logic [31:0] id0,
      input  logic iv1, input logic iw1, input logic [9:0] ia1, input logic [31:0] id1,
      output bit g0, output bit g1);
      @(negedge clk);
      rst_n = rstn;
      v0 = iv0; w0 = iw0; a0 = ia0; d0 = id0;
      v1 = iv1; w1 = iw1; a1 = ia1; d1 = id1;
      #1;
      checkOutput(g0, g1);
   endtask

   task automatic idleStep();
      bit g0, g1;
      applyStimulus(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, g0, g1);
   endtask

   task automatic resetStep();
      bit g0, g1;
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, g0, g1);
   endtask

   function automatic logic [9:0] randAddr();
      logic [9:0] base;
      base = ($urandom_range(0, 1) != 0) ? 10'h3F8 : 10'h000;
      return base | 10'($urandom_range(0, 7));
   endfunction

   initial begin
      bit          g0, g1;
      logic [9:0]  ad0, ad1;
      bit          pv0, pv1;
      logic        pw0, pw1;
      logic [9:0]  pa0, pa1;
      logic [31:0] pd0, pd1;
      int          cmds, steps;

      for (int i = 0; i < 1024; i++) smem[i] = 32'hA5A5_0000 | 32'(i);

      // Reset, then idle: everything quiet.
      resetStep();
      resetStep();
      for (int i = 0; i < 3; i++) idleStep();
      compareBit("idle_en_lit", 1, bEn[1], 1'b0);
      compareWord("idle_addr_lit", 1, 32'(bAddr[1]), 32'h0);

      // Single read of 0x005 by requester 0.
      applyStimulus(1'b1, 1'b1, 1'b0, 10'h005, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, g0, g1);
      compareBit("first_ready_lit", 1, rdy0[1], 1'b1);
      for (int i = 1; i <= 5; i++) begin
         idleStep();
         if (i == 2) begin
            compareBit("lat2_rvalid_lit", 0, rv0[0], 1'b1);
            compareWord("lat2_rdata_lit", 0, rd0[0], 32'hA5A5_0005);
         end
         if (i == 3) begin
            compareBit("lat3_rvalid_lit", 1, rv0[1], 1'b1);
            compareWord("lat3_rdata_lit", 1, rd0[1], 32'hA5A5_0005);
            compareBit("lat3_rvalid1_lit", 1, rv1[1], 1'b0);
         end
         if (i == 5) begin
            compareBit("lat5_rvalid_lit", 2, rv0[2], 1'b1);
            compareWord("lat5_rdata_lit", 2, rd0[2], 32'hA5A5_0005);
         end
      end

      // Continuous contention from reset: grants alternate starting with 0.
      resetStep();
      ad0 = 10'h010;
      ad1 = 10'h011;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, ad0, 32'h0, 1'b1, 1'b0, ad1, 32'h0, g0, g1);
         for (int g = 0; g < NI; g++) begin
            compareBit("rr_ready0_lit", g, rdy0[g], (i % 2) == 0);
         end
         if (g0) ad0 = ad0 + 10'd2;
         if (g1) ad1 = ad1 + 10'd2;
      end
      for (int i = 0; i < 6; i++) idleStep();

      // Write 0x3FF by requester 1, read it back next edge, then 0x000.
      applyStimulus(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF, g0, g1);
      applyStimulus(1'b1, 1'b1, 1'b0, 10'h3FF, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, g0, g1);
      applyStimulus(1'b1, 1'b1, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, g0, g1);
      for (int i = 1; i <= 6; i++) begin
         idleStep();
         if (i == 2) compareWord("wr_then_rd_lit", 1, rd0[1], 32'hDEAD_BEEF);
         if (i == 3) compareWord("addr0_rd_lit", 1, rd0[1], 32'hA5A5_0000);
      end

      // Reset after the second of three back-to-back reads.
      applyStimulus(1'b1, 1'b1, 1'b0, 10'h020, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, g0, g1);
      applyStimulus(1'b1, 1'b1, 1'b0, 10'h021, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, g0, g1);
      resetStep();
      applyStimulus(1'b1, 1'b1, 1'b0, 10'h022, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, g0, g1);
      for (int i = 1; i <= 6; i++) begin
         idleStep();
         if (i == 1) compareBit("dropped_rvalid_lit", 1, rv0[1], 1'b0);
         if (i == 3) begin
            compareBit("post_rst_rvalid_lit", 1, rv0[1], 1'b1);
            compareWord("post_rst_rdata_lit", 1, rd0[1], 32'hA5A5_0022);
         end
      end

      // Random mix of reads and writes from both requesters.
      pv0 = 1'b0; pv1 = 1'b0;
      pw0 = 1'b0; pw1 = 1'b0;
      pa0 = '0;   pa1 = '0;
      pd0 = '0;   pd1 = '0;
      cmds  = 0;
      steps = 0;
      while (cmds < RAND_CMDS && steps < 30000) begin
         if (!pv0 && $urandom_range(0, 99) < 70) begin
            pv0 = 1'b1;
            pw0 = 1'($urandom_range(0, 1));
            pa0 = randAddr();
            pd0 = $urandom();
         end
         if (!pv1 && $urandom_range(0, 99) < 70) begin
            pv1 = 1'b1;
            pw1 = 1'($urandom_range(0, 1));
            pa1 = randAddr();
            pd1 = $urandom();
         end
         applyStimulus(1'b1, pv0, pw0, pa0, pd0, pv1, pw1, pa1, pd1, g0, g1);
         if (g0) begin pv0 = 1'b0; cmds++; end
         if (g1) begin pv1 = 1'b0; cmds++; end
         steps++;
      end
      for (int i = 0; i < 8; i++) idleStep();
      compareBit("random_cmds_done", 1, cmds >= RAND_CMDS, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
